// File: rtl/tophat_subtract.sv
// Top-hat / baseline removal stage: delays the raw stream in a circular RAM and
// emits the saturated difference raw - baseline, LAG samples apart, as an AXI stream.
module tophat_subtract #(
    parameter int DATA_WIDTH = 16,
    parameter int LAG        = 35,
    parameter int DEPTH      = 128,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int DROP_W    = $clog2(LAG + 2)
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] axis_raw_tdata,
    input  logic                  axis_raw_tvalid,
    output logic                  axis_raw_tready,
    input  logic [DATA_WIDTH-1:0] axis_base_tdata,
    input  logic                  axis_base_tvalid,
    output logic                  axis_base_tready,
    output logic [DATA_WIDTH-1:0] axis_out_tdata,
    output logic                  axis_out_tvalid,
    input  logic                  axis_out_tready,
    output logic                  sat_flag,
    output logic [1:0]            dbg_state,
    output logic [CNT_W-1:0]      dbg_count,
    output logic [PTR_W-1:0]      dbg_wr_ptr,
    output logic [PTR_W-1:0]      dbg_rd_ptr,
    output logic [DROP_W-1:0]     dbg_drop_cnt
);

    // Every stream transfers on a cycle where tvalid && tready are both high at the
    // rising clock edge; tdata/tvalid of the output are held until that happens.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CALC  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [DROP_W-1:0] LAG_C   = DROP_W'(LAG);

    state_t                  state;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [DROP_W-1:0]       drop_cnt;
    logic [DATA_WIDTH-1:0]   base_reg;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    raw_push;
    logic                    base_hs;
    logic                    pop;
    logic                    warm;
    logic [DATA_WIDTH:0]     diff;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [DATA_WIDTH-1:0]   sat_val;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign warm     = drop_cnt < LAG_C;
    assign pop      = state == S_FETCH;
    assign raw_push = axis_raw_tvalid && axis_raw_tready;
    assign base_hs  = axis_base_tvalid && axis_base_tready;

    // Ready for baselines only uses the registered count, so a raw write landing in
    // the same cycle cannot be consumed before it is actually in the RAM.
    assign axis_raw_tready  = !areset && (count < DEPTH_C);
    assign axis_base_tready = !areset && (state == S_IDLE) && (warm || count != '0);

    // One extra bit holds the full difference; overflow shows as top two bits differing.
    assign diff   = {rd_data[DATA_WIDTH-1], rd_data} - {base_reg[DATA_WIDTH-1], base_reg};
    assign sat_hi = !diff[DATA_WIDTH] && diff[DATA_WIDTH-1];
    assign sat_lo = diff[DATA_WIDTH] && !diff[DATA_WIDTH-1];

    always_comb begin
        sat_val = diff[DATA_WIDTH-1:0];
        if (sat_hi) begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (raw_push) begin
            mem[wr_ptr] <= axis_raw_tdata;
        end
        if (pop) begin
            rd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (raw_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({raw_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state           <= S_IDLE;
            drop_cnt        <= '0;
            base_reg        <= '0;
            axis_out_tdata  <= '0;
            axis_out_tvalid <= 1'b0;
            sat_flag        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (base_hs) begin
                        // Early baselines have no raw partner yet and are discarded.
                        if (warm) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end else begin
                            base_reg <= axis_base_tdata;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_CALC;
                end
                S_CALC: begin
                    axis_out_tdata  <= sat_val;
                    axis_out_tvalid <= 1'b1;
                    if (sat_hi || sat_lo) begin
                        sat_flag <= 1'b1;
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (axis_out_tready) begin
                        axis_out_tvalid <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state    = state;
    assign dbg_count    = count;
    assign dbg_wr_ptr   = wr_ptr;
    assign dbg_rd_ptr   = rd_ptr;
    assign dbg_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_tophat_subtract.sv
// Bench for tophat_subtract: transaction model pairs raw/baseline handshakes and
// queues expected outputs; scenario tasks add targeted checks.
module tb_tophat_subtract;

    localparam int DW     = 16;
    localparam int LAG    = 3;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DROP_W = $clog2(LAG + 2);

    logic              clk = 1'b0;
    logic              areset = 1'b0;
    logic [DW-1:0]     raw_data = '0;
    logic              raw_valid = 1'b0;
    logic              raw_ready;
    logic [DW-1:0]     base_data = '0;
    logic              base_valid = 1'b0;
    logic              base_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              sat_flag;
    logic [1:0]        dbg_state;
    logic [CNT_W-1:0]  dbg_count;
    logic [PTR_W-1:0]  dbg_wr_ptr;
    logic [PTR_W-1:0]  dbg_rd_ptr;
    logic [DROP_W-1:0] dbg_drop_cnt;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    int drop_model = 0;
    logic sat_model = 1'b0;
    logic [DW-1:0] last_out = '0;
    logic [DW-1:0] exp_q[$];
    logic          exp_sat_q[$];
    logic [DW-1:0] raw_model_q[$];

    tophat_subtract #(.DATA_WIDTH(DW), .LAG(LAG), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .areset           (areset),
        .axis_raw_tdata   (raw_data),
        .axis_raw_tvalid  (raw_valid),
        .axis_raw_tready  (raw_ready),
        .axis_base_tdata  (base_data),
        .axis_base_tvalid (base_valid),
        .axis_base_tready (base_ready),
        .axis_out_tdata   (out_data),
        .axis_out_tvalid  (out_valid),
        .axis_out_tready  (out_ready),
        .sat_flag         (sat_flag),
        .dbg_state        (dbg_state),
        .dbg_count        (dbg_count),
        .dbg_wr_ptr       (dbg_wr_ptr),
        .dbg_rd_ptr       (dbg_rd_ptr),
        .dbg_drop_cnt     (dbg_drop_cnt)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: handshakes are sampled on the falling edge, inputs change at posedge+1.
    always @(negedge clk) begin
        logic [DW-1:0] r;
        logic [DW-1:0] e;
        logic          es;
        int rv, bv, d;
        if (areset) begin
            raw_model_q.delete();
            exp_q.delete();
            exp_sat_q.delete();
            drop_model = 0;
            sat_model  = 1'b0;
        end else begin
            if (raw_valid && raw_ready) raw_model_q.push_back(raw_data);
            if (base_valid && base_ready) begin
                if (drop_model < LAG) begin
                    drop_model++;
                end else if (raw_model_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pair_underflow baseline %0h accepted with no raw sample", base_data);
                end else begin
                    r  = raw_model_q.pop_front();
                    rv = int'($signed(r));
                    bv = int'($signed(base_data));
                    d  = rv - bv;
                    if (d > 32767) begin
                        d = 32767; sat_model = 1'b1;
                    end else if (d < -32768) begin
                        d = -32768; sat_model = 1'b1;
                    end
                    exp_q.push_back(DW'(d));
                    exp_sat_q.push_back(sat_model);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                out_cnt++;
                last_out = out_data;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected got %0h with empty expected queue", out_data);
                end else begin
                    e  = exp_q.pop_front();
                    es = exp_sat_q.pop_front();
                    if (out_data !== e || sat_flag !== es) begin
                        errors++;
                        $display("FAIL out_data got %0h sat %0b expected %0h sat %0b", out_data, sat_flag, e, es);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic send_raw(input logic [DW-1:0] d);
        int n = 0;
        logic hs = 1'b0;
        raw_data  = d;
        raw_valid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = raw_ready;
            n++;
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL raw_timeout data %0h never accepted", d);
        end
        @(posedge clk); #1;
        raw_valid = 1'b0;
    endtask

    task automatic send_base(input logic [DW-1:0] d);
        int n = 0;
        logic hs = 1'b0;
        base_data  = d;
        base_valid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = base_ready;
            n++;
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL base_timeout data %0h never accepted", d);
        end
        @(posedge clk); #1;
        base_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid || dbg_state != 2'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending %0d valid %0b", exp_q.size(), out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        raw_valid  = 1'b0;
        base_valid = 1'b0;
        areset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
    endtask

    task automatic drop_warmup();
        for (int i = 0; i < LAG; i++) send_base(DW'(16'h0f00 + i));
    endtask

    // Scenarios
    task automatic test_reset();
        #1 areset = 1'b1;
        @(negedge clk);
        checks++;
        if (raw_ready !== 1'b0 || base_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== '0 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rr %0b br %0b ov %0b od %0h sat %0b expected all 0",
                     raw_ready, base_ready, out_valid, out_data, sat_flag);
        end
        checks++;
        if (dbg_state !== 2'd0 || dbg_count !== '0 || dbg_drop_cnt !== '0 || dbg_wr_ptr !== '0) begin
            errors++;
            $display("FAIL reset_state got st %0d cnt %0d drop %0d wr %0d expected 0",
                     dbg_state, dbg_count, dbg_drop_cnt, dbg_wr_ptr);
        end
        @(posedge clk); #1 areset = 1'b0;
        @(negedge clk);
        checks++;
        if (raw_ready !== 1'b1 || base_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got rr %0b br %0b expected 1 1", raw_ready, base_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alignment();
        int start = out_cnt;
        fork
            for (int i = 1; i <= 8; i++) send_raw(DW'(i * 10));
            for (int i = 1; i <= 8; i++) send_base(DW'(i));
        join
        wait_idle();
        checks++;
        if (out_cnt - start != 5 || last_out !== 16'd42) begin
            errors++;
            $display("FAIL align_count got %0d outputs last %0d expected 5 last 42", out_cnt - start, last_out);
        end
        checks++;
        if (dbg_count !== CNT_W'(3)) begin
            errors++;
            $display("FAIL align_fill got %0d expected 3", dbg_count);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        drop_warmup();
        send_raw(16'h7ffe);
        send_raw(16'h7fff);
        send_raw(16'h8000);
        send_base(16'hffff);           // 32766 - (-1) = 32767 exactly, no clamp
        wait_idle();
        checks++;
        if (last_out !== 16'h7fff || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_edge got %0h sat %0b expected 7fff sat 0", last_out, sat_flag);
        end
        send_base(16'hfffb);           // 32767 - (-5)
        wait_idle();
        checks++;
        if (last_out !== 16'h7fff || sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got %0h sat %0b expected 7fff sat 1", last_out, sat_flag);
        end
        send_base(16'h0001);           // -32768 - 1
        wait_idle();
        checks++;
        if (last_out !== 16'h8000 || sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg got %0h sat %0b expected 8000 sat 1", last_out, sat_flag);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        apply_reset();
        out_ready = 1'b0;
        drop_warmup();
        send_raw(16'd100);
        send_raw(16'd200);
        send_base(16'd7);
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL bp_valid_timeout got tvalid 0 expected 1");
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (out_data !== 16'd93 || out_valid !== 1'b1 || base_ready !== 1'b0 || dbg_state !== 2'd3) begin
                errors++;
                $display("FAIL bp_hold got data %0d valid %0b br %0b st %0d expected 93 1 0 3",
                         out_data, out_valid, base_ready, dbg_state);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dbg_state !== 2'd0 || last_out !== 16'd93) begin
            errors++;
            $display("FAIL bp_release got valid %0b st %0d last %0d expected 0 0 93", out_valid, dbg_state, last_out);
        end
        @(posedge clk); #1;
        send_base(16'd8);
        wait_idle();
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 8; i++) send_raw(DW'(1000 + i));
        @(negedge clk);
        checks++;
        if (raw_ready !== 1'b0 || dbg_count !== CNT_W'(8) || dbg_wr_ptr !== '0) begin
            errors++;
            $display("FAIL full got rr %0b cnt %0d wr %0d expected 0 8 0", raw_ready, dbg_count, dbg_wr_ptr);
        end
        @(posedge clk); #1;
        drop_warmup();
        for (int i = 0; i < 4; i++) send_base(DW'(i * 3));
        wait_idle();
        checks++;
        if (raw_ready !== 1'b1 || dbg_count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL drain_part got rr %0b cnt %0d expected 1 4", raw_ready, dbg_count);
        end
        for (int i = 0; i < 4; i++) send_raw(DW'(2000 + i));
        for (int i = 0; i < 8; i++) send_base(DW'(i + 1));
        wait_idle();
        checks++;
        if (dbg_count !== '0 || dbg_rd_ptr !== PTR_W'(4) || dbg_wr_ptr !== PTR_W'(4) || last_out !== DW'(2003 - 8)) begin
            errors++;
            $display("FAIL wrap_end got cnt %0d rd %0d wr %0d last %0d expected 0 4 4 1995",
                     dbg_count, dbg_rd_ptr, dbg_wr_ptr, last_out);
        end
    endtask

    task automatic test_empty_stall();
        apply_reset();
        drop_warmup();
        base_data  = 16'd50;
        base_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (base_ready !== 1'b0) begin
                errors++;
                $display("FAIL empty_stall got base_ready %0b expected 0", base_ready);
            end
        end
        @(posedge clk); #1;
        raw_data  = 16'd500;
        raw_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (base_ready !== 1'b0 || raw_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_same_cycle got br %0b rr %0b expected 0 1", base_ready, raw_ready);
        end
        @(posedge clk); #1 raw_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (base_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_release got base_ready %0b expected 1", base_ready);
        end
        @(posedge clk); #1 base_valid = 1'b0;
        wait_idle();
        checks++;
        if (last_out !== 16'd450) begin
            errors++;
            $display("FAIL empty_result got %0d expected 450", last_out);
        end
    endtask

    task automatic test_reset_midop();
        int start;
        apply_reset();
        send_raw(16'd11);
        send_raw(16'd22);
        drop_warmup();
        send_base(16'd1);
        @(posedge clk); #1;
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL midop_state got %0d expected 2", dbg_state);
        end
        areset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dbg_count !== '0 || dbg_drop_cnt !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL midop_clear got ov %0b cnt %0d drop %0d st %0d expected 0 0 0 0",
                     out_valid, dbg_count, dbg_drop_cnt, dbg_state);
        end
        @(posedge clk); #1 areset = 1'b0;
        start = out_cnt;
        send_raw(16'd5);
        send_raw(16'd6);
        for (int i = 0; i < LAG; i++) send_base(DW'(100 + i));
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dbg_drop_cnt !== DROP_W'(LAG) || dbg_count !== CNT_W'(2) || out_cnt != start) begin
            errors++;
            $display("FAIL midop_redrop got drop %0d cnt %0d outs %0d expected 3 2 0",
                     dbg_drop_cnt, dbg_count, out_cnt - start);
        end
        send_base(16'd3);
        wait_idle();
        checks++;
        if (last_out !== 16'd2) begin
            errors++;
            $display("FAIL midop_after got %0d expected 2", last_out);
        end
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_saturation();
        test_backpressure();
        test_full_wrap();
        test_empty_stall();
        test_reset_midop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d pending outputs expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
